// File: rtl/rv_ctrl_pkg.sv
// Shared types and constants for the RV32 decode/control stage.
// The divide/multiply decode is enabled by defining RV_CTRL_MULDIV_EN.
package rv_ctrl_pkg;

  localparam int ALU_CTRL_WIDTH = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;
  localparam logic [1:0] RES_IMM = 2'd3;

  localparam logic [1:0] MASK_BYTE = 2'd0;
  localparam logic [1:0] MASK_HALF = 2'd1;
  localparam logic [1:0] MASK_WORD = 2'd2;

  typedef enum logic [ALU_CTRL_WIDTH-1:0] {
    ALU_ADD = 5'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_MUL = 5'd10, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  typedef enum logic {RUN, DIV_WAIT} state_e;

  typedef struct packed {
    logic                      regfile_write;
    logic [2:0]                immext_src;
    logic                      pc_adder_src;
    logic                      alu_src_a;
    logic                      alu_src_b;
    logic                      mem_access;
    logic                      mem_write;
    logic [1:0]                result_src;
    logic [ALU_CTRL_WIDTH-1:0] alu_ctrl;
    logic [1:0]                mask_type;
    logic                      ext_type;
    logic                      branch;
    logic                      jump;
  } ctrl_t;

  // alt selects SUB/SRA; callers only raise it where that encoding is legal
  function automatic logic [ALU_CTRL_WIDTH-1:0] alu_base(input logic [2:0] funct3,
                                                          input logic alt);
    case (funct3)
      3'b000:  alu_base = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_base = ALU_SLL;
      3'b010:  alu_base = ALU_SLT;
      3'b011:  alu_base = ALU_SLTU;
      3'b100:  alu_base = ALU_XOR;
      3'b101:  alu_base = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_base = ALU_OR;
      default: alu_base = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I(+M when RV_CTRL_MULDIV_EN is defined) control decode.
module ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl,
  output logic       illegal,
  output logic       is_div
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    is_div  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ctrl.regfile_write = 1'b1;
        ctrl.immext_src    = IMM_U;
        ctrl.result_src    = RES_IMM;
      end
      OPC_AUIPC: begin
        ctrl.regfile_write = 1'b1;
        ctrl.immext_src    = IMM_U;
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = 1'b1;
      end
      OPC_JAL: begin
        ctrl.regfile_write = 1'b1;
        ctrl.immext_src    = IMM_J;
        ctrl.result_src    = RES_PC4;
        ctrl.jump          = 1'b1;
      end
      OPC_JALR: begin
        ctrl.regfile_write = 1'b1;
        ctrl.immext_src    = IMM_I;
        ctrl.pc_adder_src  = 1'b1;
        ctrl.result_src    = RES_PC4;
        ctrl.jump          = 1'b1;
        illegal            = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        ctrl.immext_src = IMM_B;
        ctrl.branch     = 1'b1;
        case (funct3[2:1])
          2'b00:   ctrl.alu_ctrl = ALU_SUB;
          2'b10:   ctrl.alu_ctrl = ALU_SLT;
          2'b11:   ctrl.alu_ctrl = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ctrl.regfile_write = 1'b1;
        ctrl.immext_src    = IMM_I;
        ctrl.alu_src_b     = 1'b1;
        ctrl.mem_access    = 1'b1;
        ctrl.result_src    = RES_MEM;
        ctrl.mask_type     = funct3[1:0];
        ctrl.ext_type      = ~funct3[2];
        illegal            = (funct3[1:0] == 2'b11) || (funct3[2] && funct3[1]);
      end
      OPC_STORE: begin
        ctrl.immext_src = IMM_S;
        ctrl.alu_src_b  = 1'b1;
        ctrl.mem_access = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.mask_type  = funct3[1:0];
        illegal         = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OPC_OP_IMM: begin
        ctrl.regfile_write = 1'b1;
        ctrl.immext_src    = IMM_I;
        ctrl.alu_src_b     = 1'b1;
        ctrl.alu_ctrl      = alu_base(funct3, (funct3 == 3'b101) && funct7[5]);
        if (funct3 == 3'b001)
          illegal = (funct7 != F7_BASE);
        else if (funct3 == 3'b101)
          illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
      end
      OPC_OP: begin
        ctrl.regfile_write = 1'b1;
        case (funct7)
          F7_BASE: ctrl.alu_ctrl = alu_base(funct3, 1'b0);
          F7_ALT: begin
            ctrl.alu_ctrl = alu_base(funct3, 1'b1);
            illegal       = (funct3 != 3'b000) && (funct3 != 3'b101);
          end
`ifdef RV_CTRL_MULDIV_EN
          F7_MULDIV: begin
            ctrl.alu_ctrl = ALU_CTRL_WIDTH'(ALU_MUL) + ALU_CTRL_WIDTH'(funct3);
            is_div        = funct3[2];
          end
`endif
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    // an undecodable instruction must not have any side effect downstream
    if (illegal) begin
      ctrl   = '0;
      is_div = 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_stage.sv
// Registered decode stage with a multi-cycle divide occupancy FSM.
// Divide/multiply support is compiled in only when RV_CTRL_MULDIV_EN is defined.
module ctrl_stage
  import rv_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int ALU_CTRL_W = ALU_CTRL_WIDTH
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  logic       i_stall,
  input  logic       i_flush,
  output logic       o_valid,
  output ctrl_t      o_ctrl,
  output logic       o_illegal,
  output logic       o_muldiv_busy
);

  localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  if (ALU_CTRL_W != ALU_CTRL_WIDTH || DIV_CYCLES < 2 || DIV_CYCLES > 64) begin : g_param_check
    $error("ctrl_stage: unsupported ALU_CTRL_W or DIV_CYCLES");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            dec_ctrl;
  logic             dec_illegal, dec_is_div;
  logic             accept;

  ctrl_decode u_decode (
    .opcode  (i_opcode),
    .funct3  (i_funct3),
    .funct7  (i_funct7),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .is_div  (dec_is_div)
  );

  assign accept = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_flush) begin
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (accept && dec_is_div) begin
            state_d = DIV_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
        default: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= 1) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    o_ready = (state_q == RUN) && !i_stall && !i_rst;
`ifdef RV_CTRL_MULDIV_EN
    o_muldiv_busy = (state_q == DIV_WAIT);
`else
    o_muldiv_busy = 1'b0;
`endif
  end

  // a divide keeps its decoded bundle in o_ctrl and only raises o_valid on completion
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      o_valid   <= 1'b0;
      o_illegal <= 1'b0;
      o_ctrl    <= '0;
    end else if (state_q == DIV_WAIT) begin
      if (cnt_q <= 1)
        o_valid <= 1'b1;
    end else if (accept) begin
      o_ctrl    <= dec_ctrl;
      o_illegal <= dec_illegal;
      o_valid   <= !dec_is_div;
    end else if (!i_stall) begin
      o_valid   <= 1'b0;
      o_illegal <= 1'b0;
      o_ctrl    <= '0;
    end
  end

endmodule

// File: tb/tb_ctrl_stage.sv
// Directed self-checking bench for ctrl_stage (DIV_CYCLES=4).
module tb_ctrl_stage;
  import rv_ctrl_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [6:0] i_opcode = '0;
  logic [2:0] i_funct3 = '0;
  logic [6:0] i_funct7 = '0;
  logic       i_stall = 1'b0;
  logic       i_flush = 1'b0;
  logic       o_valid;
  ctrl_t      o_ctrl;
  logic       o_illegal;
  logic       o_muldiv_busy;

  int errors = 0;
  int checks = 0;
  ctrl_t lw_exp;

  ctrl_stage #(.DIV_CYCLES(4), .ALU_CTRL_W(5)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_opcode      (i_opcode),
    .i_funct3      (i_funct3),
    .i_funct7      (i_funct7),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .o_valid       (o_valid),
    .o_ctrl        (o_ctrl),
    .o_illegal     (o_illegal),
    .o_muldiv_busy (o_muldiv_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic stall, input logic flush);
    i_valid  = v;
    i_opcode = op;
    i_funct3 = f3;
    i_funct7 = f7;
    i_stall  = stall;
    i_flush  = flush;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    lw_exp               = '0;
    lw_exp.regfile_write = 1'b1;
    lw_exp.immext_src    = IMM_I;
    lw_exp.alu_src_b     = 1'b1;
    lw_exp.mem_access    = 1'b1;
    lw_exp.result_src    = RES_MEM;
    lw_exp.alu_ctrl      = ALU_ADD;
    lw_exp.mask_type     = MASK_WORD;
    lw_exp.ext_type      = 1'b1;

    // reset with a valid instruction present: nothing may be accepted
    applyStimulus(1'b1, OPC_OP, 3'b000, F7_BASE, 1'b0, 1'b0);
    checkOutput("reset_ready", 32'(o_ready), 32'd0);
    tick();
    tick();
    checkOutput("reset_valid", 32'(o_valid), 32'd0);
    checkOutput("reset_illegal", 32'(o_illegal), 32'd0);
    checkOutput("reset_ctrl", 32'(o_ctrl), 32'd0);
    checkOutput("reset_busy", 32'(o_muldiv_busy), 32'd0);

    // ADD accepted, result one cycle later
    i_rst = 1'b0;
    applyStimulus(1'b1, OPC_OP, 3'b000, F7_BASE, 1'b0, 1'b0);
    checkOutput("add_ready", 32'(o_ready), 32'd1);
    tick();
    checkOutput("add_valid", 32'(o_valid), 32'd1);
    checkOutput("add_alu", 32'(o_ctrl.alu_ctrl), 32'(ALU_ADD));
    checkOutput("add_rw", 32'(o_ctrl.regfile_write), 32'd1);
    checkOutput("add_illegal", 32'(o_illegal), 32'd0);

    applyStimulus(1'b1, OPC_OP, 3'b000, F7_ALT, 1'b0, 1'b0);
    tick();
    checkOutput("sub_alu", 32'(o_ctrl.alu_ctrl), 32'(ALU_SUB));

    applyStimulus(1'b1, OPC_OP_IMM, 3'b101, F7_ALT, 1'b0, 1'b0);
    tick();
    checkOutput("srai_alu", 32'(o_ctrl.alu_ctrl), 32'(ALU_SRA));
    checkOutput("srai_srcb", 32'(o_ctrl.alu_src_b), 32'd1);

    // LW then three stalled cycles with another instruction offered
    applyStimulus(1'b1, OPC_LOAD, 3'b010, F7_BASE, 1'b0, 1'b0);
    tick();
    checkOutput("lw_ctrl", 32'(o_ctrl), 32'(lw_exp));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, OPC_OP, 3'b000, F7_BASE, 1'b1, 1'b0);
      checkOutput("stall_ready", 32'(o_ready), 32'd0);
      tick();
      checkOutput("stall_ctrl", 32'(o_ctrl), 32'(lw_exp));
      checkOutput("stall_valid", 32'(o_valid), 32'd1);
    end
    applyStimulus(1'b0, OPC_OP, 3'b000, F7_BASE, 1'b0, 1'b0);
    tick();
    checkOutput("bubble_valid", 32'(o_valid), 32'd0);
    checkOutput("bubble_rw", 32'(o_ctrl.regfile_write), 32'd0);
    checkOutput("bubble_mem", 32'(o_ctrl.mem_access), 32'd0);

    // illegal opcode and illegal funct7 combination
    applyStimulus(1'b1, 7'b1111111, 3'b000, F7_BASE, 1'b0, 1'b0);
    tick();
    checkOutput("badop_illegal", 32'(o_illegal), 32'd1);
    checkOutput("badop_ctrl", 32'(o_ctrl), 32'd0);
    applyStimulus(1'b1, OPC_OP, 3'b001, F7_ALT, 1'b0, 1'b0);
    tick();
    checkOutput("badf7_illegal", 32'(o_illegal), 32'd1);

    // flush beats a same-cycle accept and stall
    applyStimulus(1'b1, OPC_OP, 3'b000, F7_BASE, 1'b1, 1'b1);
    tick();
    checkOutput("flush_valid", 32'(o_valid), 32'd0);
    checkOutput("flush_illegal", 32'(o_illegal), 32'd0);

    applyStimulus(1'b1, OPC_BRANCH, 3'b000, F7_BASE, 1'b0, 1'b0);
    tick();
    checkOutput("beq_branch", 32'(o_ctrl.branch), 32'd1);
    checkOutput("beq_rw", 32'(o_ctrl.regfile_write), 32'd0);
    checkOutput("beq_imm", 32'(o_ctrl.immext_src), 32'(IMM_B));

    applyStimulus(1'b1, OPC_JAL, 3'b000, F7_BASE, 1'b0, 1'b0);
    tick();
    checkOutput("jal_jump", 32'(o_ctrl.jump), 32'd1);
    checkOutput("jal_res", 32'(o_ctrl.result_src), 32'(RES_PC4));

    applyStimulus(1'b1, OPC_STORE, 3'b001, F7_BASE, 1'b0, 1'b0);
    tick();
    checkOutput("sh_memw", 32'(o_ctrl.mem_write), 32'd1);
    checkOutput("sh_mask", 32'(o_ctrl.mask_type), 32'(MASK_HALF));

    applyStimulus(1'b1, OPC_OP, 3'b000, F7_MULDIV, 1'b0, 1'b0);
    tick();
`ifdef RV_CTRL_MULDIV_EN
    checkOutput("mul_valid", 32'(o_valid), 32'd1);
    checkOutput("mul_alu", 32'(o_ctrl.alu_ctrl), 32'(ALU_MUL));
    checkOutput("mul_illegal", 32'(o_illegal), 32'd0);

    // DIVU: accept at N, busy N+1..N+3, valid at N+4
    applyStimulus(1'b1, OPC_OP, 3'b101, F7_MULDIV, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, OPC_OP, 3'b000, F7_BASE, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("divu_busy", 32'(o_muldiv_busy), 32'd1);
      checkOutput("divu_ready", 32'(o_ready), 32'd0);
      checkOutput("divu_wait_valid", 32'(o_valid), 32'd0);
      tick();
    end
    checkOutput("divu_valid", 32'(o_valid), 32'd1);
    checkOutput("divu_alu", 32'(o_ctrl.alu_ctrl), 32'(ALU_DIVU));
    checkOutput("divu_done_busy", 32'(o_muldiv_busy), 32'd0);

    // flush in the second wait cycle
    applyStimulus(1'b1, OPC_OP, 3'b101, F7_MULDIV, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, OPC_OP, 3'b000, F7_BASE, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, OPC_OP, 3'b000, F7_BASE, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, OPC_OP, 3'b000, F7_BASE, 1'b0, 1'b0);
    checkOutput("divflush_busy", 32'(o_muldiv_busy), 32'd0);
    checkOutput("divflush_valid", 32'(o_valid), 32'd0);
    checkOutput("divflush_ready", 32'(o_ready), 32'd1);
    tick();
    checkOutput("divflush_novalid", 32'(o_valid), 32'd0);

    // reset abandons a divide in progress
    applyStimulus(1'b1, OPC_OP, 3'b100, F7_MULDIV, 1'b0, 1'b0);
    tick();
    i_rst = 1'b1;
    applyStimulus(1'b0, OPC_OP, 3'b000, F7_BASE, 1'b0, 1'b0);
    tick();
`else
    checkOutput("mul_illegal", 32'(o_illegal), 32'd1);
    checkOutput("mul_rw", 32'(o_ctrl.regfile_write), 32'd0);

    // reset while holding a stalled load
    applyStimulus(1'b1, OPC_LOAD, 3'b010, F7_BASE, 1'b0, 1'b0);
    tick();
    i_rst = 1'b1;
    applyStimulus(1'b0, OPC_OP, 3'b000, F7_BASE, 1'b1, 1'b0);
    tick();
`endif
    checkOutput("midrst_valid", 32'(o_valid), 32'd0);
    checkOutput("midrst_busy", 32'(o_muldiv_busy), 32'd0);
    checkOutput("midrst_ctrl", 32'(o_ctrl), 32'd0);
    checkOutput("midrst_ready", 32'(o_ready), 32'd0);
    i_rst = 1'b0;
    applyStimulus(1'b0, OPC_OP, 3'b000, F7_BASE, 1'b0, 1'b0);
    tick();
    checkOutput("postrst_valid", 32'(o_valid), 32'd0);
    checkOutput("postrst_ready", 32'(o_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
